pe_tile_loader: RTL

Upstream feeder for the PE array controller. It accepts packed buffer words over a valid/ready stream and unpacks them into a full weight tile and then a full data tile. It then pulses load_en to latch the weights and holds compute for one systolic pass. Its outputs drive the controller's weights_in, datas_arr, load_en and compute inputs directly.

---
 rtl/pe_pkg.sv | 19 +
 rtl/pe_tile_loader_if.sv | 10 +
 rtl/tile_unpacker.sv | 27 ++
 rtl/pe_tile_loader.sv | 109 ++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants, element/tile types and FSM states for the PE tile loader.
package pe_pkg;
    localparam int ARRAY_SIZE         = 8;
    localparam int COMPUTE_DATA_WIDTH = 4;
    localparam int BUFFER_WORD_SIZE   = 16;
    localparam int NUM_COMPUTE_LANES  = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH;
    localparam int NUM_ELEMS          = ARRAY_SIZE * ARRAY_SIZE;
    localparam int WORDS_PER_TILE     = NUM_ELEMS / NUM_COMPUTE_LANES;
    localparam int COMPUTE_CYCLES     = 2 * ARRAY_SIZE - 1;
    localparam int WIDX_W             = $clog2(WORDS_PER_TILE);
    localparam int CCNT_W             = $clog2(COMPUTE_CYCLES);

    typedef logic signed [COMPUTE_DATA_WIDTH-1:0] elem_t;
    typedef elem_t [NUM_ELEMS-1:0]                tile_t;

    typedef enum logic [2:0] {
        IDLE, LOAD_W, LOAD_D, LATCH, COMPUTE, DONE
    } state_t;
endpackage

// File: rtl/pe_tile_loader_if.sv
// Packed buffer word stream (valid/ready) feeding the tile loader.
interface pe_tile_loader_if;
    import pe_pkg::*;
    logic [BUFFER_WORD_SIZE-1:0] word_data;
    logic                        word_valid;
    logic                        word_ready;

    modport master (output word_data, output word_valid, input  word_ready);
    modport slave  (input  word_data, input  word_valid, output word_ready);
endinterface

// File: rtl/tile_unpacker.sv
// Tile register file: one buffer word writes NUM_COMPUTE_LANES consecutive elements.
module tile_unpacker
    import pe_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_wr_en,
    input  logic [WIDX_W-1:0]           i_wr_word_idx,
    input  logic [BUFFER_WORD_SIZE-1:0] i_word_data,
    output tile_t                       o_tile
);
    tile_t r_mem;

    // Element e lives in word e/LANES, lane e%LANES; constant indices keep the decode flat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '0;
        end else if (i_wr_en) begin
            for (int e = 0; e < NUM_ELEMS; e++) begin
                if (i_wr_word_idx == WIDX_W'(e / NUM_COMPUTE_LANES))
                    r_mem[e] <= i_word_data[(e % NUM_COMPUTE_LANES)*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH];
            end
        end
    end

    assign o_tile = r_mem;
endmodule

// File: rtl/pe_tile_loader.sv
// Loads a weight tile then a data tile from the word stream, strobes load_en, holds compute for one pass.
module pe_tile_loader
    import pe_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    pe_tile_loader_if.slave          s_word,
    output tile_t                    weights_in,
    output tile_t                    datas_arr,
    output logic                     load_en,
    output logic                     compute,
    output logic                     busy,
    output logic                     done
);
    state_t              r_state, w_next;
    logic [WIDX_W-1:0]   r_word_cnt, w_word_cnt_nxt;
    logic [CCNT_W-1:0]   r_cmp_cnt, w_cmp_cnt_nxt;
    logic                r_word_ready, r_load_en, r_compute, r_busy, r_done;
    logic                w_xfer, w_wr_w, w_wr_d;

    // abort wins over an offered word: it is never consumed
    assign w_xfer = r_word_ready & s_word.word_valid & ~abort;
    assign w_wr_w = w_xfer & (r_state == LOAD_W);
    assign w_wr_d = w_xfer & (r_state == LOAD_D);

    always_comb begin
        w_next         = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_cmp_cnt_nxt  = r_cmp_cnt;
        case (r_state)
            IDLE:    if (start) w_next = LOAD_W;
            LOAD_W, LOAD_D: begin
                if (w_xfer) begin
                    if (r_word_cnt == WIDX_W'(WORDS_PER_TILE-1)) begin
                        w_word_cnt_nxt = '0;
                        w_next         = (r_state == LOAD_W) ? LOAD_D : LATCH;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + 1'b1;
                    end
                end
            end
            LATCH:   w_next = COMPUTE;
            COMPUTE: begin
                if (r_cmp_cnt == CCNT_W'(COMPUTE_CYCLES-1)) begin
                    w_cmp_cnt_nxt = '0;
                    w_next        = DONE;
                end else begin
                    w_cmp_cnt_nxt = r_cmp_cnt + 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (abort && r_state != IDLE) begin
            w_next         = IDLE;
            w_word_cnt_nxt = '0;
            w_cmp_cnt_nxt  = '0;
        end
    end

    // Outputs are registered decodes of the next state, so they track r_state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_word_cnt   <= '0;
            r_cmp_cnt    <= '0;
            r_word_ready <= 1'b0;
            r_load_en    <= 1'b0;
            r_compute    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_word_cnt   <= w_word_cnt_nxt;
            r_cmp_cnt    <= w_cmp_cnt_nxt;
            r_word_ready <= (w_next == LOAD_W) || (w_next == LOAD_D);
            r_load_en    <= (w_next == LATCH);
            r_compute    <= (w_next == COMPUTE);
            r_busy       <= (w_next != IDLE);
            r_done       <= (w_next == DONE);
        end
    end

    tile_unpacker u_weights (
        .clk          (clk),
        .rst          (rst),
        .i_wr_en      (w_wr_w),
        .i_wr_word_idx(r_word_cnt),
        .i_word_data  (s_word.word_data),
        .o_tile       (weights_in)
    );

    tile_unpacker u_datas (
        .clk          (clk),
        .rst          (rst),
        .i_wr_en      (w_wr_d),
        .i_wr_word_idx(r_word_cnt),
        .i_word_data  (s_word.word_data),
        .o_tile       (datas_arr)
    );

    assign s_word.word_ready = r_word_ready;
    assign load_en           = r_load_en;
    assign compute           = r_compute;
    assign busy              = r_busy;
    assign done              = r_done;
endmodule
